ibyte_source: RTL and testbench

- Instruction-byte producer for the fetch stage: walks the program counter, issues reads to a synchronous instruction memory, and streams bytes in program order over a valid/ready handshake.
- Sits between instruction memory and the fetch FSM; fetch consumes one byte per accepted handshake.
- Holds a small prefetch FIFO to hide memory latency.
- Supports a PC redirect from execute (branch/jump/interrupt vector) that flushes all speculative bytes.

---
 rtl/nes_pkg.sv | 18 +
 rtl/ibyte_fifo.sv | 46 ++++
 rtl/ibyte_source.sv | 96 +++++++++
 tb/tb_ibyte_source.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES/6502 fetch front end.
//   BYTE          - data width of instruction memory
//   ADDR_W        - program counter / address width
//   RESET_PC      - PC loaded on reset
//   ibyte_state_t - control states of the byte source
//   ibyte_entry_t - one prefetched byte plus the address it came from
package nes_pkg;
  localparam int BYTE   = 8;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h8000;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} ibyte_state_t;

  typedef struct packed {
    logic [BYTE-1:0]   data;
    logic [ADDR_W-1:0] pc;
  } ibyte_entry_t;
endpackage

// File: rtl/ibyte_fifo.sv
// Prefetch FIFO of {byte, pc} entries.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   push, din     : write din at the tail
//   pop           : drop the head entry (caller only pops when count != 0)
//   flush         : empty the FIFO; wins over push and pop
//   count         : number of valid entries (0..DEPTH)
//   head          : oldest entry, all-zero when empty
module ibyte_fifo
  import nes_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  ibyte_entry_t din,
  output logic [CW-1:0] count,
  output ibyte_entry_t head
);
  ibyte_entry_t      mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk_i) begin
    if (rstn_i && !flush && push) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/ibyte_source.sv
// Instruction-byte producer: walks the PC, reads a 1-cycle-latency
// instruction memory and streams {byte, pc} in program order over
// valid/ready. A redirect flushes every speculative byte.
//   clk_i, rstn_i         : clock, synchronous active-low reset
//   redirect_i            : single-cycle pulse, load redirect_pc_i and flush
//   redirect_pc_i         : new PC
//   mem_req_o, mem_addr_o : read request / address to instruction memory
//   mem_rdata_i           : read data, one cycle after the request
//   byte_o, byte_pc_o     : head-of-stream byte and its address
//   byte_valid_o          : head is valid
//   byte_ready_i          : consumer takes the head this cycle
module ibyte_source #(
  parameter int                ADDR_W     = nes_pkg::ADDR_W,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = nes_pkg::RESET_PC
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     redirect_i,
  input  logic [ADDR_W-1:0]        redirect_pc_i,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [nes_pkg::BYTE-1:0] mem_rdata_i,
  output logic [nes_pkg::BYTE-1:0] byte_o,
  output logic [ADDR_W-1:0]        byte_pc_o,
  output logic                     byte_valid_o,
  input  logic                     byte_ready_i
);
  import nes_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ibyte_state_t      state, state_next;
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic              room, push, pop;
  ibyte_entry_t      din, head;

  // Space is reserved for the read in flight, so a push never lands on a full FIFO.
  assign room = (count + CW'(inflight)) < CW'(FIFO_DEPTH);

  always_comb begin
    state_next = state;
    mem_req_o  = 1'b0;
    unique case (state)
      S_INIT:  state_next = S_RUN;
      S_RUN:   mem_req_o  = room;
      S_FLUSH: state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
    // Redirect overrides everything in its cycle.
    if (redirect_i) begin
      state_next = S_FLUSH;
      mem_req_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state    <= S_INIT;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_next;
      // mem_req_o is forced low on redirect, so this also kills nothing
      // further: the response returning during the redirect cycle is
      // blocked from the FIFO by the push gate below.
      inflight <= mem_req_o;
      req_pc   <= fetch_pc;
      if (redirect_i)     fetch_pc <= redirect_pc_i;
      else if (mem_req_o) fetch_pc <= fetch_pc + 1'b1;
    end
  end

  assign mem_addr_o   = fetch_pc;
  assign push         = inflight && !redirect_i;
  assign byte_valid_o = (count != '0) && !redirect_i;
  assign pop          = byte_valid_o && byte_ready_i;
  assign din          = '{data: mem_rdata_i, pc: req_pc};

  ibyte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_i),
    .din    (din),
    .count  (count),
    .head   (head)
  );

  assign byte_o    = head.data;
  assign byte_pc_o = head.pc;
endmodule

// File: tb/tb_ibyte_source.sv
// Scoreboard bench for ibyte_source. The reference model is the program
// stream itself: after a reset or redirect to P, the consumer must see
// exactly mem[P], mem[P+1], ... (16-bit wrap) in order, regardless of
// memory latency, FIFO occupancy or backpressure.
module tb_ibyte_source;
  localparam logic [15:0] RST_PC = 16'h8000;

  logic        clk = 1'b0, rstn = 1'b0, redirect = 1'b0, ready = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        mem_req, bvalid;
  logic [15:0] mem_addr, byte_pc;
  logic [7:0]  rdata = '0, bytev;

  always #5 clk = ~clk;

  ibyte_source dut (
    .clk_i(clk), .rstn_i(rstn), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(rdata),
    .byte_o(bytev), .byte_pc_o(byte_pc), .byte_valid_o(bvalid), .byte_ready_i(ready)
  );

  int n_checks = 0, n_pass = 0, n_pop = 0;
  logic [7:0] key = '0;

  // Program image: mem[a] = a[7:0] ^ key (key = 0 gives mem[a] = a[7:0]).
  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ key;
  endfunction

  // Synchronous memory: data valid exactly one cycle after the request, garbage otherwise.
  always @(posedge clk) rdata <= mem_req ? memf(mem_addr) : 8'($urandom);

  typedef struct packed { logic [7:0] d; logic [15:0] pc; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] req_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // A new program stream starts at pc: push its expected bytes.
  task automatic restart(input logic [15:0] pc);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back('{d: memf(pc + 16'(i)), pc: pc + 16'(i)});
  endtask

  // Monitor: logs requests, checks every handshake against the scoreboard
  // and checks the head is held while stalled.
  initial begin
    logic stall_q;
    exp_t held, e;
    stall_q = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (mem_req) req_log.push_back(mem_addr);
        if (stall_q && !redirect) begin
          check("hold_valid", 32'(bvalid), 32'd1);
          check("hold_pc", 32'(byte_pc), 32'(held.pc));
          check("hold_byte", 32'(bytev), 32'(held.d));
        end
        if (bvalid && ready) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: byte %h pc %h with nothing expected", bytev, byte_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", 32'(byte_pc), 32'(e.pc));
            check("sb_byte", 32'(bytev), 32'(e.d));
          end
        end
        stall_q = bvalid && !ready;
        held    = '{d: bytev, pc: byte_pc};
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic first_req(input string name, input logic [15:0] expv);
    logic [31:0] a;
    a = (req_log.size() > 0) ? 32'(req_log[0]) : 32'hFFFF_FFFF;
    check(name, a, 32'(expv));
  endtask

  // Hold reset for ncyc edges, check reset outputs, release and check the
  // first byte appears on the 3rd cycle after release.
  task automatic do_reset(input logic rdy, input int ncyc);
    int n;
    rstn = 1'b0; redirect = 1'b0; ready = rdy;
    repeat (ncyc) tick();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(bvalid), 32'd0);
    check("rst_byte", 32'(bytev), 32'd0);
    check("rst_pc", 32'(byte_pc), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'(RST_PC));
    restart(RST_PC);
    req_log.delete();
    rstn = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("rst_latency", n, 3);
    first_req("rst_first_req", RST_PC);
    check("rst_first_pc", 32'(byte_pc), 32'(RST_PC));
  endtask

  // Redirect in the current cycle; first valid comes after flush,
  // request and response cycles, i.e. in cycle R+4.
  task automatic redirect_to(input logic [15:0] pc);
    int n;
    redirect = 1'b1; redirect_pc = pc;
    restart(pc);
    req_log.delete();
    #1;
    check("redir_no_valid", 32'(bvalid), 32'd0);
    check("redir_no_req", 32'(mem_req), 32'd0);
    tick();
    redirect = 1'b0;
    n = 1;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("redir_latency", n, 4);
    first_req("redir_first_req", pc);
    check("redir_first_pc", 32'(byte_pc), 32'(pc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    int nv, cnt;
    logic found;
    // Streaming from reset at full throughput.
    do_reset(1'b1, 3);
    check("first_byte", 32'(bytev), 32'h00);
    nv = 0;
    repeat (20) begin if (bvalid) nv++; tick(); end
    check("throughput", nv, 20);

    // Backpressure from reset: only FIFO_DEPTH requests, then hold.
    do_reset(1'b0, 2);
    repeat (9) tick();
    check("bp_req_count", req_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < req_log.size()) check("bp_req_addr", 32'(req_log[i]), 32'(RST_PC + 16'(i)));
    check("bp_req_stopped", 32'(mem_req), 32'd0);
    check("bp_head_byte", 32'(bytev), 32'h00);
    ready = 1'b1;
    nv = 0;
    repeat (5) begin if (bvalid) nv++; tick(); end
    check("bp_no_gap", nv, 5);

    // Redirect with a filling FIFO and a read in flight.
    ready = 1'b0; tick(); tick();
    ready = 1'b1;
    redirect_to(16'hC123);
    repeat (6) tick();

    // Redirect across the address wrap.
    redirect_to(16'hFFFE);
    repeat (8) tick();

    // Back-to-back redirects: only the second target is ever fetched.
    redirect = 1'b1; redirect_pc = 16'h9000; restart(16'h9000); req_log.delete();
    tick();
    redirect_pc = 16'hA000; restart(16'hA000);
    tick();
    redirect = 1'b0;
    repeat (10) tick();
    cnt = 0;
    foreach (req_log[i]) if (req_log[i] == 16'h9000) cnt++;
    check("b2b_no_9000", cnt, 0);
    first_req("b2b_first_req", 16'hA000);

    // One-cycle reset mid-stream while the read of 8005 is in flight.
    do_reset(1'b1, 2);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req && mem_addr == 16'h8005) begin found = 1'b1; break; end
      tick();
    end
    check("mid_find_8005", 32'(found), 32'd1);
    tick();
    do_reset(1'b1, 1);

    // Randomized traffic with a random program image.
    key = 8'($urandom);
    do_reset(1'b1, 2);
    n_pop = 0;
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 999);
      ready = ($urandom_range(0, 9) < 7);
      if (r < 5) begin
        rstn = 1'b0; redirect = 1'b0; restart(RST_PC);
        tick();
        rstn = 1'b1;
      end else if (r < 40) begin
        redirect = 1'b1; redirect_pc = 16'($urandom); restart(redirect_pc);
        tick();
      end else begin
        redirect = 1'b0;
        tick();
      end
    end
    redirect = 1'b0;
    check("rand_progress", 32'(n_pop > 150), 32'd1);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
